// File: rtl/prodos_hdd_pkg.sv
// rtl/prodos_hdd_pkg.sv - shared codes, register offsets and state type for the ProDOS block controller
package prodos_hdd_pkg;

    localparam logic [7:0] CMD_STATUS = 8'h00;
    localparam logic [7:0] CMD_READ   = 8'h01;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_FORMAT = 8'h03;

    localparam logic [7:0] RES_OK         = 8'h00;
    localparam logic [7:0] RES_BAD_CMD    = 8'h01;
    localparam logic [7:0] RES_IO_ERR     = 8'h27;
    localparam logic [7:0] RES_NO_DEV     = 8'h28;
    localparam logic [7:0] RES_WRITE_PROT = 8'h2B;
    localparam logic [7:0] RES_BUSY       = 8'h80;

    localparam logic [3:0] REG_EXEC   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h1;
    localparam logic [3:0] REG_CMD    = 4'h2;
    localparam logic [3:0] REG_UNIT   = 4'h3;
    localparam logic [3:0] REG_MEM_L  = 4'h4;
    localparam logic [3:0] REG_MEM_H  = 4'h5;
    localparam logic [3:0] REG_BLK_L  = 4'h6;
    localparam logic [3:0] REG_BLK_H  = 4'h7;
    localparam logic [3:0] REG_DATA   = 4'h8;

    typedef enum logic {IDLE, REQ} hdd_state_t;

    // Phantom-slot units map to indices 2/3, drive bit selects within the pair
    function automatic logic [1:0] unit_index(input logic [7:0] unit, input logic [2:0] alt_slot);
        return {unit[6:4] == alt_slot, unit[7]};
    endfunction

endpackage

// File: rtl/hdd_sector_ram.sv
// rtl/hdd_sector_ram.sv - 512x8 true dual-port sector buffer, 1-cycle read on both ports
module hdd_sector_ram (
    input  logic       CLK_14M,
    input  logic [8:0] a_addr,
    input  logic [7:0] a_din,
    input  logic       a_we,
    output logic [7:0] a_dout,
    input  logic [8:0] b_addr,
    input  logic [7:0] b_din,
    input  logic       b_we,
    output logic [7:0] b_dout
);

    logic [7:0] mem [512];

    // Port a (host) is written last so it wins a same-address collision
    always_ff @(posedge CLK_14M) begin
        if (b_we) mem[b_addr] <= b_din;
        if (a_we) mem[a_addr] <= a_din;
        a_dout <= mem[a_addr];
        b_dout <= mem[b_addr];
    end

endmodule

// File: rtl/prodos_hdd_ctrl.sv
// rtl/prodos_hdd_ctrl.sv - multi-unit non-halting ProDOS block controller with host req/ack and timeout
module prodos_hdd_ctrl
    import prodos_hdd_pkg::*;
#(
    parameter int          NUM_UNITS      = 2,
    parameter int          SLOT           = 7,
    parameter int          ALT_SLOT       = 4,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd14_000_000
) (
    input  logic                 CLK_14M,
    input  logic                 RESET,
    input  logic                 PHASE_ZERO,
    input  logic                 IO_SELECT,
    input  logic                 DEVICE_SELECT,
    input  logic [15:0]          A,
    input  logic                 RD,
    input  logic [7:0]           D_IN,
    output logic [7:0]           D_OUT,
    input  logic [7:0]           rom_dout,
    output logic [15:0]          lba,
    output logic [1:0]           hdd_unit,
    output logic                 hdd_read,
    output logic                 hdd_write,
    input  logic                 hdd_ack,
    input  logic [NUM_UNITS-1:0] hdd_mounted,
    input  logic [NUM_UNITS-1:0] hdd_protect,
    input  logic [8:0]           ram_addr,
    input  logic [7:0]           ram_di,
    output logic [7:0]           ram_do,
    input  logic                 ram_we
);

    hdd_state_t  state_q, state_d;
    logic        sel_d;
    logic        op_write_q;
    logic [23:0] tmo_q;
    logic        err_q;
    logic [7:0]  last_result;
    logic [7:0]  cmd_q, unit_q, mem_l_q, mem_h_q, blk_l_q, blk_h_q;
    logic [8:0]  ptr_q;
    logic        ptr_pend;
    logic [7:0]  exec_q;

    logic        strobe, busy, exec_fire, go, launch, cpu_wr, data_acc;
    logic        ack_done, tmo_done;
    logic [3:0]  reg_idx;
    logic [1:0]  unit_idx;
    logic        unit_valid, dev_ok, dev_prot;
    logic [3:0]  mnt4, prot4;
    logic [7:0]  exec_res, rd_val, cpu_rdata;
    logic        unused_addr;

    assign unused_addr = ^A[15:4];
    assign reg_idx     = A[3:0];
    assign strobe      = PHASE_ZERO & DEVICE_SELECT & ~sel_d;
    assign busy        = (state_q == REQ);
    assign exec_fire   = strobe & RD & (reg_idx == REG_EXEC);
    assign go          = exec_fire & launch;
    assign cpu_wr      = strobe & ~RD & ~busy;
    assign data_acc    = strobe & (reg_idx == REG_DATA) & (RD | ~busy);

    always_comb begin
        mnt4  = '0;
        prot4 = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            mnt4[i]  = hdd_mounted[i];
            prot4[i] = hdd_protect[i];
        end
    end

    assign unit_idx   = unit_index(unit_q, 3'(ALT_SLOT));
    assign unit_valid = (unit_q[3:0] == 4'h0)
                      && ((unit_q[6:4] == 3'(SLOT)) || (unit_q[6:4] == 3'(ALT_SLOT)))
                      && ({30'd0, unit_idx} < 32'(NUM_UNITS));
    assign dev_ok     = unit_valid & mnt4[unit_idx];
    assign dev_prot   = prot4[unit_idx];

    always_comb begin
        exec_res = RES_BAD_CMD;
        launch   = 1'b0;
        if (busy) begin
            exec_res = RES_BUSY;
        end else begin
            case (cmd_q)
                CMD_STATUS: exec_res = dev_ok ? RES_OK : RES_NO_DEV;
                CMD_READ: begin
                    exec_res = dev_ok ? RES_OK : RES_NO_DEV;
                    launch   = dev_ok;
                end
                CMD_WRITE: begin
                    exec_res = !dev_ok ? RES_NO_DEV : (dev_prot ? RES_WRITE_PROT : RES_OK);
                    launch   = dev_ok & ~dev_prot;
                end
                CMD_FORMAT: exec_res = !dev_ok ? RES_NO_DEV : (dev_prot ? RES_WRITE_PROT : RES_OK);
                default:    exec_res = RES_BAD_CMD;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        ack_done  = 1'b0;
        tmo_done  = 1'b0;
        hdd_read  = 1'b0;
        hdd_write = 1'b0;
        case (state_q)
            IDLE: if (go) state_d = REQ;
            REQ: begin
                hdd_read  = ~op_write_q;
                hdd_write = op_write_q;
                if (hdd_ack) begin
                    state_d  = IDLE;
                    ack_done = 1'b1;
                end else if (tmo_q == TIMEOUT_CYCLES - 24'd1) begin
                    state_d  = IDLE;
                    tmo_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_val = 8'hFF;
        case (reg_idx)
            REG_EXEC:   rd_val = strobe ? exec_res : exec_q;
            REG_STATUS: rd_val = {busy, 6'b0, err_q};
            REG_CMD:    rd_val = cmd_q;
            REG_UNIT:   rd_val = unit_q;
            REG_MEM_L:  rd_val = mem_l_q;
            REG_MEM_H:  rd_val = mem_h_q;
            REG_BLK_L:  rd_val = blk_l_q;
            REG_BLK_H:  rd_val = blk_h_q;
            REG_DATA:   rd_val = cpu_rdata;
            default:    rd_val = 8'hFF;
        endcase
    end

    always_ff @(posedge CLK_14M) begin
        if (RESET) begin
            state_q     <= IDLE;
            sel_d       <= 1'b0;
            op_write_q  <= 1'b0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            last_result <= '0;
            cmd_q       <= '0;
            unit_q      <= '0;
            mem_l_q     <= '0;
            mem_h_q     <= '0;
            blk_l_q     <= '0;
            blk_h_q     <= '0;
            ptr_q       <= '0;
            ptr_pend    <= 1'b0;
            exec_q      <= '0;
            lba         <= '0;
            hdd_unit    <= '0;
            D_OUT       <= 8'hFF;
        end else begin
            state_q <= state_d;
            if (PHASE_ZERO) sel_d <= DEVICE_SELECT;

            if (go) begin
                tmo_q      <= '0;
                lba        <= {blk_h_q, blk_l_q};
                hdd_unit   <= unit_idx;
                op_write_q <= (cmd_q == CMD_WRITE);
            end else if (state_q == REQ) begin
                tmo_q <= tmo_q + 24'd1;
            end

            if (exec_fire) begin
                exec_q <= exec_res;
                if (!busy) begin
                    ptr_q       <= '0;
                    err_q       <= (exec_res != RES_OK);
                    last_result <= exec_res;
                end
            end
            if (ack_done) begin
                err_q       <= 1'b0;
                last_result <= RES_OK;
            end
            if (tmo_done) begin
                err_q       <= 1'b1;
                last_result <= RES_IO_ERR;
            end

            if (cpu_wr) begin
                case (reg_idx)
                    REG_CMD: begin
                        cmd_q <= D_IN;
                        ptr_q <= '0;
                    end
                    REG_UNIT:  unit_q  <= D_IN;
                    REG_MEM_L: mem_l_q <= D_IN;
                    REG_MEM_H: mem_h_q <= D_IN;
                    REG_BLK_L: blk_l_q <= D_IN;
                    REG_BLK_H: blk_h_q <= D_IN;
                    default: ;
                endcase
            end

            // Pointer advances once the access ends so the whole access sees one byte
            if (data_acc) ptr_pend <= 1'b1;
            if (PHASE_ZERO && !DEVICE_SELECT && ptr_pend) begin
                ptr_q    <= ptr_q + 9'd1;
                ptr_pend <= 1'b0;
            end

            if (PHASE_ZERO) begin
                if (IO_SELECT && RD)          D_OUT <= rom_dout;
                else if (DEVICE_SELECT && RD) D_OUT <= rd_val;
                else                          D_OUT <= 8'hFF;
            end
        end
    end

    hdd_sector_ram u_ram (
        .CLK_14M (CLK_14M),
        .a_addr  (ram_addr),
        .a_din   (ram_di),
        .a_we    (ram_we),
        .a_dout  (ram_do),
        .b_addr  (ptr_q),
        .b_din   (D_IN),
        .b_we    (cpu_wr && (reg_idx == REG_DATA)),
        .b_dout  (cpu_rdata)
    );

endmodule

// File: tb/tb_prodos_hdd_ctrl.sv
// tb/tb_prodos_hdd_ctrl.sv - directed and randomized checks of prodos_hdd_ctrl against a behavioural model
module tb_prodos_hdd_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, pz, io_sel, sel_a, sel_b, rd_sig;
    logic [15:0] addr;
    logic [7:0]  d_in, rom_dout, dout_a, dout_b;
    logic [15:0] lba_a, lba_b;
    logic [1:0]  unit_a, unit_b;
    logic        hr_a, hw_a, hr_b, hw_b, ack_a, ack_b, we_a, we_b;
    logic [3:0]  mnt_a, prot_a;
    logic [0:0]  mnt_b, prot_b;
    logic [8:0]  ram_addr;
    logic [7:0]  ram_di, rdo_a, rdo_b;

    prodos_hdd_ctrl #(.NUM_UNITS(4)) dut_a (
        .CLK_14M(clk), .RESET(reset), .PHASE_ZERO(pz), .IO_SELECT(io_sel),
        .DEVICE_SELECT(sel_a), .A(addr), .RD(rd_sig), .D_IN(d_in), .D_OUT(dout_a),
        .rom_dout(rom_dout), .lba(lba_a), .hdd_unit(unit_a), .hdd_read(hr_a),
        .hdd_write(hw_a), .hdd_ack(ack_a), .hdd_mounted(mnt_a), .hdd_protect(prot_a),
        .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(rdo_a), .ram_we(we_a));

    prodos_hdd_ctrl #(.NUM_UNITS(1), .TIMEOUT_CYCLES(24'd100)) dut_b (
        .CLK_14M(clk), .RESET(reset), .PHASE_ZERO(pz), .IO_SELECT(io_sel),
        .DEVICE_SELECT(sel_b), .A(addr), .RD(rd_sig), .D_IN(d_in), .D_OUT(dout_b),
        .rom_dout(rom_dout), .lba(lba_b), .hdd_unit(unit_b), .hdd_read(hr_b),
        .hdd_write(hw_b), .hdd_ack(ack_b), .hdd_mounted(mnt_b), .hdd_protect(prot_b),
        .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(rdo_b), .ram_we(we_b));

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] model_buf [512];
    logic [7:0] cmds [4] = '{8'h00, 8'h03, 8'h05, 8'h81};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected execute result derived directly from the unit/command rules
    function automatic logic [7:0] exp_exec(input logic [7:0] cmd, input logic [7:0] u,
                                            input logic [3:0] mnt, input logic [3:0] prot, input int nu);
        int slot = int'(u[6:4]);
        int idx  = (slot == 4 ? 2 : 0) + (u[7] ? 1 : 0);
        bit ok   = (u[3:0] == 4'h0) && (slot == 7 || slot == 4) && (idx < nu) && mnt[idx];
        if (cmd == 8'h00 || cmd == 8'h01) return ok ? 8'h00 : 8'h28;
        if (cmd == 8'h02 || cmd == 8'h03) return !ok ? 8'h28 : (prot[idx] ? 8'h2B : 8'h00);
        return 8'h01;
    endfunction

    task automatic cpu_acc(input bit which, input bit rd, input logic [3:0] idx,
                           input logic [7:0] wd, output logic [7:0] rdata);
        @(negedge clk);
        addr   = {12'hC0F, idx};
        rd_sig = rd;
        d_in   = wd;
        if (which) sel_b = 1'b1; else sel_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rdata = which ? dout_b : dout_a;
        sel_a = 1'b0;
        sel_b = 1'b0;
        rd_sig = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic cpu_wr(input bit which, input logic [3:0] idx, input logic [7:0] wd);
        logic [7:0] dummy;
        cpu_acc(which, 1'b0, idx, wd, dummy);
    endtask

    task automatic cpu_rd(input bit which, input logic [3:0] idx, output logic [7:0] rdata);
        cpu_acc(which, 1'b1, idx, 8'h00, rdata);
    endtask

    initial begin
        logic [7:0]  r, u, c, e;
        logic [15:0] blk;
        int          hi;

        reset = 1'b1; pz = 1'b1; io_sel = 1'b0; sel_a = 1'b0; sel_b = 1'b0; rd_sig = 1'b1;
        addr = 16'hC0F0; d_in = 8'h00; rom_dout = 8'h00;
        ack_a = 1'b0; ack_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
        mnt_a = 4'h0; prot_a = 4'h0; mnt_b = 1'b0; prot_b = 1'b0;
        ram_addr = 9'd0; ram_di = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_dout", {8'h0, dout_a}, 16'h00FF);
        check("reset_req", {14'h0, hr_a, hw_a}, 16'h0000);
        check("reset_lba", lba_a, 16'h0000);
        check("reset_unit", {14'h0, unit_a}, 16'h0000);
        cpu_rd(0, 4'h1, r); check("reset_status", {8'h0, r}, 16'h0000);
        cpu_rd(0, 4'h2, r); check("reset_cmd", {8'h0, r}, 16'h0000);
        cpu_rd(0, 4'hC, r); check("reg_c_ff", {8'h0, r}, 16'h00FF);

        @(negedge clk);
        io_sel = 1'b1; rd_sig = 1'b1; rom_dout = 8'($urandom);
        @(negedge clk);
        check("rom_read", {8'h0, dout_a}, {8'h0, rom_dout});
        io_sel = 1'b0;

        mnt_b = 1'b1; mnt_a = 4'b0001;
        cpu_wr(1, 4'h3, 8'h70); cpu_wr(1, 4'h2, 8'h00);
        cpu_rd(1, 4'h0, r); check("b_status_70", {8'h0, r}, 16'h0000);
        cpu_wr(0, 4'h3, 8'h70); cpu_wr(0, 4'h2, 8'h00);
        cpu_rd(0, 4'h0, r); check("a_status_70", {8'h0, r}, 16'h0000);
        cpu_wr(1, 4'h3, 8'hF0);
        cpu_rd(1, 4'h0, r); check("b_status_f0", {8'h0, r}, 16'h0028);
        cpu_rd(1, 4'h1, r); check("b_err_bit", {8'h0, r}, 16'h0001);

        pz = 1'b0;
        cpu_wr(1, 4'h2, 8'h33);
        pz = 1'b1;
        cpu_rd(1, 4'h2, r); check("pz_low_ignored", {8'h0, r}, 16'h0000);

        for (int k = 0; k < 24; k++) begin
            u = {1'($urandom), ($urandom_range(0, 2) == 0) ? 3'($urandom) : (($urandom_range(0, 1) == 0) ? 3'd7 : 3'd4),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0};
            c = cmds[$urandom_range(0, 3)];
            mnt_a = 4'($urandom); prot_a = 4'($urandom);
            e = exp_exec(c, u, mnt_a, prot_a, 4);
            cpu_wr(0, 4'h3, u); cpu_wr(0, 4'h2, c);
            cpu_rd(0, 4'h0, r); check($sformatf("rand_exec u=%h c=%h", u, c), {8'h0, r}, {8'h0, e});
            cpu_rd(0, 4'h1, r); check("rand_status", {8'h0, r}, {15'h0, e != 8'h00});
            check("rand_no_req", {14'h0, hr_a, hw_a}, 16'h0000);
        end

        mnt_a = 4'b0100; prot_a = 4'($urandom);
        blk = 16'($urandom);
        cpu_wr(0, 4'h3, 8'h40); cpu_wr(0, 4'h6, blk[7:0]); cpu_wr(0, 4'h7, blk[15:8]);
        cpu_wr(0, 4'h2, 8'h01);
        cpu_rd(0, 4'h0, r); check("read_launch", {8'h0, r}, 16'h0000);
        check("read_req", {14'h0, hr_a, hw_a}, 16'h0002);
        check("read_lba", lba_a, blk);
        check("read_unit", {14'h0, unit_a}, 16'h0002);
        cpu_rd(0, 4'h0, r); check("busy_exec", {8'h0, r}, 16'h0080);
        cpu_rd(0, 4'h1, r); check("busy_status", {8'h0, r}, 16'h0080);
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            ram_addr = 9'(i); ram_di = 8'(i); we_a = 1'b1;
            model_buf[i] = 8'(i);
        end
        @(negedge clk);
        we_a = 1'b0; ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        check("read_drop", {15'h0, hr_a}, 16'h0000);
        cpu_rd(0, 4'h1, r); check("read_done_status", {8'h0, r}, 16'h0000);
        for (int i = 0; i < 513; i++) begin
            cpu_rd(0, 4'h8, r);
            check($sformatf("ramp[%0d]", i), {8'h0, r}, {8'h0, model_buf[i % 512]});
        end

        mnt_a = 4'b0001; prot_a = 4'b0001;
        cpu_wr(0, 4'h3, 8'h70); cpu_wr(0, 4'h2, 8'h02);
        cpu_rd(0, 4'h0, r); check("write_prot", {8'h0, r}, 16'h002B);
        repeat (3) @(negedge clk);
        check("write_prot_noreq", {14'h0, hr_a, hw_a}, 16'h0000);
        cpu_rd(0, 4'h1, r); check("write_prot_status", {8'h0, r}, 16'h0001);
        prot_a = 4'b0000;
        blk = 16'($urandom);
        cpu_wr(0, 4'h6, blk[7:0]); cpu_wr(0, 4'h7, blk[15:8]);
        cpu_wr(0, 4'h2, 8'h02);
        for (int i = 0; i < 512; i++) begin
            model_buf[i] = 8'($urandom);
            cpu_wr(0, 4'h8, model_buf[i]);
        end
        cpu_rd(0, 4'h0, r); check("write_launch", {8'h0, r}, 16'h0000);
        check("write_req", {14'h0, hr_a, hw_a}, 16'h0001);
        check("write_lba", lba_a, blk);
        check("write_unit", {14'h0, unit_a}, 16'h0000);
        cpu_wr(0, 4'h8, ~model_buf[0]);
        cpu_wr(0, 4'h2, 8'h00);
        cpu_rd(0, 4'h2, r); check("busy_cmd_kept", {8'h0, r}, 16'h0002);
        cpu_rd(0, 4'h1, r); check("busy_status_w", {8'h0, r}, 16'h0080);
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            ram_addr = 9'(i);
            @(negedge clk);
            check($sformatf("host_rd[%0d]", i), {8'h0, rdo_a}, {8'h0, model_buf[i]});
        end
        ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        check("write_drop", {15'h0, hw_a}, 16'h0000);
        cpu_rd(0, 4'h1, r); check("write_done_status", {8'h0, r}, 16'h0000);

        cpu_wr(1, 4'h3, 8'h70); cpu_wr(1, 4'h2, 8'h01);
        cpu_rd(1, 4'h0, r); check("tmo_launch", {8'h0, r}, 16'h0000);
        hi = 3;
        for (int k = 0; k < 300 && hr_b; k++) begin
            hi++;
            @(negedge clk);
        end
        check("tmo_cycles", 16'(hi), 16'd100);
        cpu_rd(1, 4'h1, r); check("tmo_status", {8'h0, r}, 16'h0001);
        check("tmo_last_result", {8'h0, dut_b.last_result}, 16'h0027);

        cpu_wr(1, 4'h6, 8'h5C);
        cpu_rd(1, 4'h0, r); check("rst_launch", {8'h0, r}, 16'h0000);
        repeat (5) @(negedge clk);
        check("rst_req_before", {15'h0, hr_b}, 16'h0001);
        reset = 1'b1;
        @(negedge clk);
        check("rst_req_drop", {15'h0, hr_b}, 16'h0000);
        check("rst_dout", {8'h0, dout_b}, 16'h00FF);
        reset = 1'b0;
        check("rst_lba", lba_b, 16'h0000);
        cpu_rd(1, 4'h6, r); check("rst_blk_l", {8'h0, r}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
